// File: rtl/ps2_scan_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame geometry,
// prefix byte values, frame FSM state encoding and the queued event layout.
package ps2_scan_rx_pkg;

    // Start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    // Bits captured after the start bit (data, parity, stop)
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Width of one queued key event: {keyup, extend, scancode}
    localparam int PS2_EVENT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic       keyup;
        logic       extend;
        logic [7:0] code;
    } key_event_t;

    // Captured shift register layout: [7:0] data, [8] parity, [9] stop.
    // A frame is good when data+parity hold an odd number of ones and stop is 1.
    function automatic logic frame_ok(input logic [PS2_SHIFT_BITS-1:0] sh);
        return (^sh[8:0]) & sh[9];
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO for decoded key events. Push while full is
// accepted only when a pop happens in the same cycle; pop while empty is
// ignored. Head data reads as zero when empty.
module ps2_event_fifo #(
    parameter int AW = 3,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receive front end: pin synchronizer, 11-bit frame
// deframer, E0/F0 prefix folding and a key event FIFO popped by the
// active-low nextdata_n strobe.
// Optional build macro PS2_TIMEOUT_EN adds a mid-frame watchdog that
// abandons a frame after TIMEOUT_CYC clk cycles without a PS/2 clock edge.
module ps2_scan_rx #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic       keyup,
    output logic       extend,
    output logic [7:0] scancode,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    import ps2_scan_rx_pkg::*;

    // Synchronizer chains: [0] first stage, [1] synchronized, [2] edge history
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       fall;
    logic       data_s;

    frame_state_e              state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_SHIFT_BITS-1:0] shift_q, shift_d;
    logic                      ext_pend_q, ext_pend_d;
    logic                      brk_pend_q, brk_pend_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overflow_q, overflow_d;

    logic       push;
    key_event_t push_ev;
    key_event_t head_ev;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;
`endif
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);

    // Pin synchronizers; idle level is high so reset to ones avoids a
    // spurious falling edge right after reset
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
    end

    // Synchronizer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    // Falling edge of the synchronized PS/2 clock: previously high, now low
    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s = data_sync_q[1];

    assign pop = ~nextdata_n & ~fifo_empty;

`ifdef PS2_TIMEOUT_EN
    // Watchdog counts cycles in SHIFT since the last PS/2 clock edge
    always_comb begin
        to_cnt_d = '0;
        if ((state_q == ST_SHIFT) && !fall) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

    // Frame FSM next state, prefix folding and event push
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_ev     = '0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    // LSB-first: new bits enter at the top and move down
                    shift_d = {data_s, shift_q[PS2_SHIFT_BITS-1:1]};
                    if (bit_cnt_q == 4'(PS2_SHIFT_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
`ifdef PS2_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                    frame_err_d = 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok(shift_q)) begin
                    if (shift_q[7:0] == PS2_PREFIX_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q[7:0] == PS2_PREFIX_BRK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        push           = 1'b1;
                        push_ev.keyup  = brk_pend_q;
                        push_ev.extend = ext_pend_q;
                        push_ev.code   = shift_q[7:0];
                        ext_pend_d     = 1'b0;
                        brk_pend_d     = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow: set when an event is dropped, cleared by any pop
    always_comb begin
        overflow_d = overflow_q;
        if (pop) begin
            overflow_d = 1'b0;
        end else if (push && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Frame FSM, prefix flags, error pulse and overflow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .AW (FIFO_AW),
        .DW (PS2_EVENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_ev),
        .rdata (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready     = ~fifo_empty;
    assign keyup     = head_ev.keyup;
    assign extend    = head_ev.extend;
    assign scancode  = head_ev.code;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: frames are bit-banged on the PS/2 pins, expected
// events are queued as they are sent, and a monitor pops and compares the
// DUT head whenever ready is high and popping is enabled.
// Valid/ready here: an event is offered while ready=1 and consumed on the
// clk edge where nextdata_n is low.
module tb_ps2_scan_rx;

  localparam int FIFO_AW     = 3;
  localparam int TIMEOUT_CYC = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic       keyup;
  logic       extend;
  logic [7:0] scancode;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic pop_en = 1'b0;
  int err_pulses = 0;
  int err_run = 0;
  int err_max_run = 0;

  ps2_scan_rx #(
    .FIFO_AW     (FIFO_AW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .keyup      (keyup),
    .extend     (extend),
    .scancode   (scancode),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Drive the first nbits of a frame; sync_pop raises pop_en for exactly the
  // clk cycle in which the final bit's event is pushed
  task automatic send_raw(input logic [10:0] frame, input int nbits, input bit sync_pop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (3) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk);
        #1;
        if (sync_pop && i == nbits - 1) pop_en = (c == 3);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_raw(mk_frame(d, 1'b0), 11, 1'b0);
  endtask

  task automatic expect_ev(input bit ku, input bit ex, input logic [7:0] code);
    exp_q.push_back({ku, ex, code});
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || ready === 1'b1) && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_ready_low"}, {31'b0, ready}, 0);
    check({tag, "_empty_head"}, {22'b0, keyup, extend, scancode}, 0);
  endtask

  // monitor: compare head against scoreboard, then pop it for one cycle
  initial begin
    nextdata_n = 1'b1;
    forever begin
      @(negedge clk);
      if (nextdata_n == 1'b0) begin
        nextdata_n = 1'b1;
      end else if (pop_en && ready === 1'b1 && rst === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", {keyup, extend, scancode});
        end else begin
          check("event", {22'b0, keyup, extend, scancode}, {22'b0, exp_q.pop_front()});
        end
        nextdata_n = 1'b0;
      end
    end
  end

  // frame_err pulse counter and width tracker
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        err_run++;
        if (err_run == 1) err_pulses++;
        if (err_run > err_max_run) err_max_run = err_run;
      end else begin
        err_run = 0;
      end
    end
  end

  // global time bound
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] codes [9];
    int e0;
    int i;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    // reset
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_keyup", {31'b0, keyup}, 0);
    check("rst_extend", {31'b0, extend}, 0);
    check("rst_scancode", {24'b0, scancode}, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // single make code
    pop_en = 1'b1;
    expect_ev(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C);
    wait_drain("single");

    // prefix folding
    expect_ev(1'b1, 1'b1, 8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_ev(1'b1, 1'b0, 8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_ev(1'b0, 1'b1, 8'h6B);
    send_byte(8'hE0);
    send_byte(8'h6B);
    wait_drain("prefix");

    // overflow: nine events into an eight-deep queue
    pop_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expect_ev(1'b0, 1'b0, codes[k]);
      send_byte(codes[k]);
    end
    repeat (5) @(posedge clk);
    #1;
    check("ovf_set", {31'b0, overflow}, 1);
    check("ovf_ready", {31'b0, ready}, 1);
    check("ovf_head", {24'b0, scancode}, {24'b0, codes[0]});
    pop_en = 1'b1;
    i = 0;
    while (exp_q.size() > 7 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk);
    #1;
    check("ovf_clear_on_pop", {31'b0, overflow}, 0);
    wait_drain("ovf");

    // bad parity drops the frame and the pending prefix
    e0 = err_pulses;
    send_byte(8'hE0);
    send_raw(mk_frame(8'h1C, 1'b1), 11, 1'b0);
    repeat (4) @(posedge clk);
    check("parity_err_pulse", err_pulses - e0, 1);
    expect_ev(1'b0, 1'b0, 8'h1B);
    send_byte(8'h1B);
    wait_drain("parity");

    // start bit of 1 is rejected in IDLE
    e0 = err_pulses;
    send_raw(11'h7FF, 1, 1'b0);
    repeat (4) @(posedge clk);
    check("start_err_pulse", err_pulses - e0, 1);
    expect_ev(1'b0, 1'b0, 8'h29);
    send_byte(8'h29);
    wait_drain("start");

    // full queue with push and pop in the same cycle
    pop_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_ev(1'b0, 1'b0, codes[k]);
      send_byte(codes[k]);
    end
    expect_ev(1'b0, 1'b0, 8'h4B);
    send_raw(mk_frame(8'h4B, 1'b0), 11, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("simul_no_overflow", {31'b0, overflow}, 0);
    check("simul_ready", {31'b0, ready}, 1);
    check("simul_left", exp_q.size(), 8);
    pop_en = 1'b1;
    wait_drain("simul");

    // reset in mid-frame discards the partial frame
    send_raw(mk_frame(8'h1C, 1'b0), 5, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    expect_ev(1'b0, 1'b0, 8'h33);
    send_byte(8'h33);
    wait_drain("midrst");

`ifdef PS2_TIMEOUT_EN
    // truncated frame abandoned by the watchdog
    e0 = err_pulses;
    send_raw(mk_frame(8'h1C, 1'b0), 5, 1'b0);
    repeat (TIMEOUT_CYC + 30) @(posedge clk);
    check("timeout_err_pulse", err_pulses - e0, 1);
    expect_ev(1'b0, 1'b0, 8'h2A);
    send_byte(8'h2A);
    wait_drain("timeout");
`endif

    check("frame_err_width", err_max_run, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
